// File: rtl/riscv_trace_fifo_if.sv
// -----------------------------------------------------------------------------
// riscv_trace_fifo_if
// Drain-side valid/ready bus of the trace capture buffer.
//   out_valid  head entry available            (driven by the FIFO)
//   out_ready  consumer accepts the head entry (driven by the consumer)
//   out_kind   2'b00 reg write, 2'b01 store, 2'b10 load
//   out_idx    register number (zero-extended) or memory address
//   out_data   write-back, store or load data
// Modports: master = trace FIFO side, slave = consumer side.
// -----------------------------------------------------------------------------
interface riscv_trace_fifo_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_kind;
    logic [ADDR_W-1:0] out_idx;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_kind,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_kind,
        input  out_idx,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/riscv_trace_fifo.sv
// -----------------------------------------------------------------------------
// riscv_trace_fifo
// Trace capture buffer for the rv32i core observation ports. Each cycle up to
// two retired events (one memory event, one register write) are packed into
// tagged entries and queued in a DEPTH-entry FIFO, drained through a
// show-ahead valid/ready port.
// Ports:
//   clk, reset (sync, active-low), clear (sync flush)
//   en_mask[2:0]  per-kind capture enable: [0] reg write, [1] store, [2] load
//   stop_on_full  freeze capture on the first drop caused by a full FIFO
//   reg_write_sig/reg_num/reg_data       core register write-back
//   wr/rd/addr/wr_data/rd_data           core data memory access
//   trace         drain bus (riscv_trace_fifo_if.master)
//   count         occupied entries
//   drop_cnt      dropped events, saturating at 16'hFFFF
//   frozen        capture halted (draining still allowed)
// -----------------------------------------------------------------------------
module riscv_trace_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [2:0]                 en_mask,
    input  logic                       stop_on_full,
    input  logic                       reg_write_sig,
    input  logic [REG_W-1:0]           reg_num,
    input  logic [DATA_W-1:0]          reg_data,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W-1:0]          rd_data,
    riscv_trace_fifo_if.master         trace,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [15:0]                drop_cnt,
    output logic                       frozen
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] KIND_REG   = 2'b00;
    localparam logic [1:0] KIND_STORE = 2'b01;
    localparam logic [1:0] KIND_LOAD  = 2'b10;

    // Entry storage (no reset needed: the output mux gates it with count)
    logic [1:0]        kind_mem_q [DEPTH];
    logic [ADDR_W-1:0] idx_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [CW-1:0] count_q,    count_d;
    logic [PW-1:0] wptr_q,     wptr_d;
    logic [PW-1:0] rptr_q,     rptr_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          frozen_q,   frozen_d;

    logic              mem_cand_s;
    logic [1:0]        mem_kind_s;
    logic [DATA_W-1:0] mem_data_s;
    logic              load_drop_s;
    logic              reg_cand_s;
    logic [1:0]        n_cand_s;
    logic [CW-1:0]     free_s;
    logic [1:0]        pushes_s;
    logic [1:0]        drops_s;
    logic              full_drop_s;
    logic              mem_push_s;
    logic              reg_push_s;
    logic [PW-1:0]     reg_ptr_s;
    logic              pop_s;
    logic [16:0]       drop_sum_s;

    // Candidate selection: store wins over load, everything gated by en_mask and frozen
    always_comb begin
        mem_cand_s  = 1'b0;
        mem_kind_s  = KIND_REG;
        mem_data_s  = {DATA_W{1'b0}};
        load_drop_s = 1'b0;
        reg_cand_s  = 1'b0;
        if (!frozen_q) begin
            if (wr) begin
                mem_cand_s  = en_mask[1];
                mem_kind_s  = KIND_STORE;
                mem_data_s  = wr_data;
                // simultaneous load loses to the store and counts as a drop
                load_drop_s = rd & en_mask[2];
            end else if (rd) begin
                mem_cand_s  = en_mask[2];
                mem_kind_s  = KIND_LOAD;
                mem_data_s  = rd_data;
            end else begin
                mem_cand_s  = 1'b0;
            end
            reg_cand_s = reg_write_sig & en_mask[0];
        end else begin
            mem_cand_s = 1'b0;
            reg_cand_s = 1'b0;
        end
    end

    // Admission: free space comes from the registered count only, so a
    // same-cycle pop never makes room for a push
    always_comb begin
        n_cand_s = {1'b0, mem_cand_s} + {1'b0, reg_cand_s};
        free_s   = DEPTH_C - count_q;
        if (free_s >= CW'(2'd2)) begin
            pushes_s = n_cand_s;
        end else if (free_s == CW'(1'b1)) begin
            pushes_s = (n_cand_s != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            pushes_s = 2'd0;
        end
        full_drop_s = (n_cand_s > pushes_s);
        drops_s     = (n_cand_s - pushes_s) + {1'b0, load_drop_s};
        // mem entry always takes the first granted slot
        mem_push_s  = mem_cand_s && (pushes_s != 2'd0);
        reg_push_s  = reg_cand_s && ((pushes_s == 2'd2) || (!mem_cand_s && (pushes_s == 2'd1)));
        reg_ptr_s   = mem_push_s ? (wptr_q + PW'(1'b1)) : wptr_q;
        pop_s       = (count_q != {CW{1'b0}}) && trace.out_ready;
    end

    // Next-state for pointers, occupancy, drop counter and freeze flag
    always_comb begin
        wptr_d     = wptr_q + PW'(pushes_s);
        rptr_d     = rptr_q + PW'(pop_s);
        count_d    = count_q + CW'(pushes_s) - CW'(pop_s);
        drop_sum_s = {1'b0, drop_cnt_q} + 17'(drops_s);
        if (drop_sum_s[16]) begin
            drop_cnt_d = 16'hFFFF;
        end else begin
            drop_cnt_d = drop_sum_s[15:0];
        end
        if (stop_on_full && full_drop_s) begin
            frozen_d = 1'b1;
        end else begin
            frozen_d = frozen_q;
        end
    end

    // Control state register with sync reset and clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q    <= {CW{1'b0}};
            wptr_q     <= {PW{1'b0}};
            rptr_q     <= {PW{1'b0}};
            drop_cnt_q <= 16'h0000;
            frozen_q   <= 1'b0;
        end else if (clear) begin
            count_q    <= {CW{1'b0}};
            wptr_q     <= {PW{1'b0}};
            rptr_q     <= {PW{1'b0}};
            drop_cnt_q <= 16'h0000;
            frozen_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            drop_cnt_q <= drop_cnt_d;
            frozen_q   <= frozen_d;
        end
    end

    // Entry write port: mem entry at wptr, reg entry right after it
    always_ff @(posedge clk) begin
        if (reset && !clear) begin
            if (mem_push_s) begin
                kind_mem_q[wptr_q] <= mem_kind_s;
                idx_mem_q[wptr_q]  <= addr;
                data_mem_q[wptr_q] <= mem_data_s;
            end
            if (reg_push_s) begin
                kind_mem_q[reg_ptr_s] <= KIND_REG;
                idx_mem_q[reg_ptr_s]  <= ADDR_W'(reg_num);
                data_mem_q[reg_ptr_s] <= reg_data;
            end
        end
    end

    // Show-ahead head: entry at rptr while non-empty, zeros otherwise
    always_comb begin
        if (count_q != {CW{1'b0}}) begin
            trace.out_valid = 1'b1;
            trace.out_kind  = kind_mem_q[rptr_q];
            trace.out_idx   = idx_mem_q[rptr_q];
            trace.out_data  = data_mem_q[rptr_q];
        end else begin
            trace.out_valid = 1'b0;
            trace.out_kind  = 2'b00;
            trace.out_idx   = {ADDR_W{1'b0}};
            trace.out_data  = {DATA_W{1'b0}};
        end
    end

    assign count    = count_q;
    assign drop_cnt = drop_cnt_q;
    assign frozen   = frozen_q;

endmodule

// File: tb/tb_riscv_trace_fifo.sv
module tb_riscv_trace_fifo;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int REG_W  = 5;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset, clear, stop_on_full;
    logic [2:0]        en_mask;
    logic              reg_write_sig, wr, rd;
    logic [REG_W-1:0]  reg_num;
    logic [DATA_W-1:0] reg_data, wr_data, rd_data;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     count;
    logic [15:0]       drop_cnt;
    logic              frozen;

    always #5 clk = ~clk;

    riscv_trace_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) tr ();

    riscv_trace_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear), .en_mask(en_mask),
        .stop_on_full(stop_on_full), .reg_write_sig(reg_write_sig),
        .reg_num(reg_num), .reg_data(reg_data), .wr(wr), .rd(rd),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .trace(tr), .count(count), .drop_cnt(drop_cnt), .frozen(frozen)
    );

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } ent_t;

    // reference model: a plain queue of events plus counters
    ent_t m_q[$];
    int   m_drop;
    bit   m_frozen;
    int   errors = 0;
    int   checks = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        ent_t cands[$];
        ent_t e;
        int   space;
        int   drops;
        bit   full_drop;
        if (!reset || clear) begin
            m_q.delete();
            m_drop   = 0;
            m_frozen = 0;
        end else begin
            drops     = 0;
            full_drop = 0;
            if (!m_frozen) begin
                if (wr) begin
                    if (en_mask[1]) begin
                        e = '{2'b01, addr, wr_data};
                        cands.push_back(e);
                    end
                    if (rd && en_mask[2]) drops++;
                end else if (rd && en_mask[2]) begin
                    e = '{2'b10, addr, rd_data};
                    cands.push_back(e);
                end
                if (reg_write_sig && en_mask[0]) begin
                    e = '{2'b00, ADDR_W'(reg_num), reg_data};
                    cands.push_back(e);
                end
            end
            space = DEPTH - m_q.size();
            if (m_q.size() != 0 && tr.out_ready) void'(m_q.pop_front());
            foreach (cands[i]) begin
                if (space > 0) begin
                    m_q.push_back(cands[i]);
                    space--;
                end else begin
                    drops++;
                    full_drop = 1;
                end
            end
            m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
            if (full_drop && stop_on_full) m_frozen = 1;
        end
    endtask

    task automatic check_all();
        ent_t h;
        h = (m_q.size() != 0) ? m_q[0] : '0;
        check_val("out_valid", 64'(tr.out_valid), 64'(m_q.size() != 0));
        check_val("out_head", 64'({tr.out_kind, tr.out_idx, tr.out_data}), 64'(h));
        check_val("count", 64'(count), 64'(m_q.size()));
        check_val("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check_val("frozen", 64'(frozen), 64'(m_frozen));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        reg_write_sig = 1'b0;
        wr            = 1'b0;
        rd            = 1'b0;
    endtask

    task automatic push_regs(input int n);
        for (int i = 0; i < n; i++) begin
            reg_write_sig = 1'b1;
            reg_num       = REG_W'($urandom);
            reg_data      = $urandom;
            tick();
        end
        idle();
    endtask

    initial begin
        int d0;
        reset = 1'b0; clear = 1'b0; stop_on_full = 1'b0; en_mask = 3'b111;
        reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
        wr = 1'b1; rd = 1'b0; addr = '0; wr_data = 32'h1234_5678; rd_data = '0;
        tr.out_ready = 1'b0;
        m_drop = 0; m_frozen = 0;

        // 1. reset held two cycles with a store strobe active
        tick(); tick();
        check_val("t1_count", 64'(count), 64'd0);
        reset = 1'b1; wr = 1'b0;
        tick();

        // 2. load to x7 together with a load event
        rd = 1'b1; addr = 9'h040; rd_data = 32'hDEAD_BEEF;
        reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'hDEAD_BEEF;
        tick();
        idle();
        check_val("t2_count", 64'(count), 64'd2);
        check_val("t2_head0", 64'({tr.out_kind, tr.out_idx, tr.out_data}), {21'd0, 2'b10, 9'h040, 32'hDEAD_BEEF});
        tick();
        check_val("t2_hold", 64'({tr.out_kind, tr.out_idx, tr.out_data}), {21'd0, 2'b10, 9'h040, 32'hDEAD_BEEF});
        tr.out_ready = 1'b1;
        tick();
        tr.out_ready = 1'b0;
        check_val("t2_head1", 64'({tr.out_kind, tr.out_idx, tr.out_data}), {21'd0, 2'b00, 9'h007, 32'hDEAD_BEEF});
        tr.out_ready = 1'b1;
        tick();
        tr.out_ready = 1'b0;

        // 3. fill with 17 single reg writes
        push_regs(17);
        check_val("t3_count", 64'(count), 64'd16);
        check_val("t3_drop", 64'(drop_cnt), 64'd1);
        check_val("t3_frozen", 64'(frozen), 64'd0);

        // 4. freeze on full
        clear = 1'b1; tick(); clear = 1'b0;
        push_regs(16);
        stop_on_full = 1'b1;
        wr = 1'b1; addr = 9'h1F0; wr_data = 32'hCAFE_0001;
        tick();
        check_val("t4_drop", 64'(drop_cnt), 64'd1);
        check_val("t4_frozen", 64'(frozen), 64'd1);
        for (int i = 0; i < 3; i++) begin
            wr_data = $urandom;
            tick();
        end
        idle();
        check_val("t4_drop_hold", 64'(drop_cnt), 64'd1);
        tr.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        tr.out_ready = 1'b0;
        check_val("t4_empty", 64'(count), 64'd0);
        check_val("t4_still_frozen", 64'(frozen), 64'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        check_val("t4_unfrozen", 64'(frozen), 64'd0);
        stop_on_full = 1'b0;

        // 5a. stores only
        en_mask = 3'b010;
        for (int i = 0; i < 12; i++) begin
            wr = 1'($urandom); rd = 1'($urandom); reg_write_sig = 1'($urandom);
            addr = ADDR_W'($urandom); wr_data = $urandom; rd_data = $urandom;
            reg_num = REG_W'($urandom); reg_data = $urandom;
            tr.out_ready = 1'($urandom);
            tick();
        end
        idle();
        tr.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        tr.out_ready = 1'b0;
        // 5b. store and load together
        en_mask = 3'b111;
        clear = 1'b1; tick(); clear = 1'b0;
        wr = 1'b1; rd = 1'b1; addr = 9'h0AA; wr_data = 32'h5555_AAAA;
        tick();
        idle();
        check_val("t5_wrrd_drop", 64'(drop_cnt), 64'd1);
        check_val("t5_wrrd_head", 64'({tr.out_kind, tr.out_idx, tr.out_data}), {21'd0, 2'b01, 9'h0AA, 32'h5555_AAAA});
        // 5c. count=15 plus load+regwrite
        push_regs(14);
        d0 = m_drop;
        rd = 1'b1; addr = 9'h101; rd_data = 32'h0BAD_F00D;
        reg_write_sig = 1'b1; reg_num = 5'd3; reg_data = 32'h1111_2222;
        tick();
        idle();
        check_val("t5_c15_count", 64'(count), 64'd16);
        check_val("t5_c15_drop", 64'(drop_cnt), 64'(d0 + 1));

        // 6. push+pop at full, then steady push+pop at count 8
        tr.out_ready = 1'b1;
        reg_write_sig = 1'b1; reg_data = 32'h7777_0000;
        tick();
        idle();
        check_val("t6_full_pop", 64'(count), 64'd15);
        for (int i = 0; i < 7; i++) tick();
        check_val("t6_eight", 64'(count), 64'd8);
        for (int i = 0; i < 20; i++) begin
            reg_write_sig = 1'b1; reg_num = REG_W'(i); reg_data = 32'(i);
            tick();
        end
        idle();
        check_val("t6_steady", 64'(count), 64'd8);
        tr.out_ready = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(199) != 0);
            clear         = ($urandom_range(63) == 0);
            en_mask       = 3'($urandom);
            stop_on_full  = ($urandom_range(7) == 0);
            reg_write_sig = 1'($urandom); wr = 1'($urandom); rd = 1'($urandom);
            reg_num = REG_W'($urandom); reg_data = $urandom;
            addr = ADDR_W'($urandom); wr_data = $urandom; rd_data = $urandom;
            tr.out_ready = ($urandom_range(2) != 0);
            tick();
        end

        // drop counter saturation
        reset = 1'b1; clear = 1'b1; stop_on_full = 1'b0; en_mask = 3'b111;
        tr.out_ready = 1'b0;
        tick();
        clear = 1'b0;
        wr = 1'b1; rd = 1'b1; reg_write_sig = 1'b1;
        for (int i = 0; i < 22000; i++) tick();
        idle();
        check_val("sat_drop", 64'(drop_cnt), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
